// File: rtl/fetch_pkg.sv
// Constants and types shared by the instruction-fetch stage.
// FETCH_ADEL_EN enables the address-error (AdEL) check on fetch addresses.
package fetch_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam logic [31:0] IM_LIMIT = 32'h0000_6FFF;
    localparam logic [4:0]  EXC_ADEL = 5'd4;

    typedef enum logic {
        FETCH,
        HOLD
    } fetch_state_e;

    // Misaligned or outside the instruction memory window.
    function automatic logic addr_err(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LIMIT);
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry buffer that parks a fetched word while decode is stalled.
// With FETCH_ADEL_EN the parked exception code travels with the word.
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
`ifdef FETCH_ADEL_EN
    input  logic [4:0]  load_exc,
    output logic [4:0]  hold_exc,
`endif
    output logic        valid,
    output logic [31:0] hold_pc,
    output logic [31:0] hold_instr
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid      <= 1'b0;
            hold_pc    <= 32'h0;
            hold_instr <= 32'h0;
`ifdef FETCH_ADEL_EN
            hold_exc   <= 5'd0;
`endif
        end else if (load) begin
            valid      <= 1'b1;
            hold_pc    <= load_pc;
            hold_instr <= load_instr;
`ifdef FETCH_ADEL_EN
            hold_exc   <= load_exc;
`endif
        end else if (clear) begin
            valid      <= 1'b0;
            hold_pc    <= 32'h0;
            hold_instr <= 32'h0;
`ifdef FETCH_ADEL_EN
            hold_exc   <= 5'd0;
`endif
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// MIPS IF stage: PC register, variable-latency I-mem requests, IF/ID register,
// delay-slot redirect handling. FETCH_ADEL_EN adds the AdEL fetch-address check.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_D,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic [31:0] im_rdata,
    output logic [31:0] PC_F,
    output logic [31:0] PC_D,
    output logic [31:0] instr_D,
`ifdef FETCH_ADEL_EN
    output logic [4:0]  exc_code_D,
`endif
    output logic        valid_D
);

    import fetch_pkg::*;

    fetch_state_e state;
    logic         pend_valid;
    logic [31:0]  pend_target;
    logic         fetch_done;
    logic [31:0]  fetch_word;
    logic [31:0]  nxt_pc;
    logic         hold_valid;
    logic         hold_release;
    logic [31:0]  hold_pc;
    logic [31:0]  hold_instr;

`ifdef FETCH_ADEL_EN
    logic         adel;
    logic [4:0]   fetch_exc;
    logic [4:0]   hold_exc;

    // A bad address completes at once with a zero word instead of going to memory.
    assign adel       = addr_err(PC_F);
    assign im_req     = (state == FETCH) && !adel;
    assign fetch_done = (state == FETCH) && (im_ready || adel);
    assign fetch_word = adel ? 32'h0 : im_rdata;
    assign fetch_exc  = adel ? EXC_ADEL : 5'd0;
`else
    assign im_req     = (state == FETCH);
    assign fetch_done = (state == FETCH) && im_ready;
    assign fetch_word = im_rdata;
`endif

    assign im_addr      = PC_F;
    assign nxt_pc       = pend_valid     ? pend_target     :
                          redirect_valid ? redirect_target : PC_F + 32'd4;
    assign hold_release = (state == HOLD) && hold_valid && !stall_D;

    fetch_hold_buf u_hold_buf (
        .clk        (clk),
        .reset      (reset),
        .load       (fetch_done && stall_D),
        .clear      (hold_release),
        .load_pc    (PC_F),
        .load_instr (fetch_word),
`ifdef FETCH_ADEL_EN
        .load_exc   (fetch_exc),
        .hold_exc   (hold_exc),
`endif
        .valid      (hold_valid),
        .hold_pc    (hold_pc),
        .hold_instr (hold_instr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            PC_F        <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= 32'h0;
            PC_D        <= 32'h0;
            instr_D     <= 32'h0;
            valid_D     <= 1'b0;
`ifdef FETCH_ADEL_EN
            exc_code_D  <= 5'd0;
`endif
        end else begin
            unique case (state)
                FETCH: begin
                    if (fetch_done) begin
                        PC_F       <= nxt_pc;
                        pend_valid <= 1'b0;
                        if (stall_D) begin
                            state <= HOLD;
                        end else begin
                            PC_D    <= PC_F;
                            instr_D <= fetch_word;
                            valid_D <= 1'b1;
`ifdef FETCH_ADEL_EN
                            exc_code_D <= fetch_exc;
`endif
                        end
                    end else begin
                        if (!stall_D) begin
                            instr_D <= 32'h0;
                            valid_D <= 1'b0;
`ifdef FETCH_ADEL_EN
                            exc_code_D <= 5'd0;
`endif
                        end
                        // Outstanding fetch is the delay slot; remember where to go after it.
                        if (redirect_valid && !pend_valid) begin
                            pend_valid  <= 1'b1;
                            pend_target <= redirect_target;
                        end
                    end
                end
                HOLD: begin
                    // Delay slot is already parked, so the target is the next fetch.
                    if (redirect_valid) begin
                        PC_F <= redirect_target;
                    end
                    if (hold_release) begin
                        state   <= FETCH;
                        PC_D    <= hold_pc;
                        instr_D <= hold_instr;
                        valid_D <= 1'b1;
`ifdef FETCH_ADEL_EN
                        exc_code_D <= hold_exc;
`endif
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit; covers AdEL when FETCH_ADEL_EN is defined.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_D;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready;
    logic [31:0] im_rdata;
    logic [31:0] PC_F;
    logic [31:0] PC_D;
    logic [31:0] instr_D;
    logic        valid_D;
`ifdef FETCH_ADEL_EN
    logic [4:0]  exc_code_D;
`endif

    int checks = 0;
    int errors = 0;
    int hits_300c = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign im_rdata = mem_word(im_addr);

    fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall_D         (stall_D),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .im_req          (im_req),
        .im_addr         (im_addr),
        .im_ready        (im_ready),
        .im_rdata        (im_rdata),
        .PC_F            (PC_F),
        .PC_D            (PC_D),
        .instr_D         (instr_D),
`ifdef FETCH_ADEL_EN
        .exc_code_D      (exc_code_D),
`endif
        .valid_D         (valid_D)
    );

    always @(posedge clk) begin
        if (!reset && im_req && im_addr == 32'h0000_300C) hits_300c++;
    end

    typedef struct {
        logic        rst;
        logic        stall;
        logic        rv;
        logic [31:0] tgt;
        logic        rdy;
        logic [31:0] pcf;
        logic        req;
        logic [31:0] pcd;
        logic        vld;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(input logic rst, input logic stall, input logic rv,
                                input logic [31:0] tgt, input logic rdy, input logic [31:0] pcf,
                                input logic req, input logic [31:0] pcd, input logic vld);
        vec_t v;
        v.rst = rst; v.stall = stall; v.rv = rv; v.tgt = tgt; v.rdy = rdy;
        v.pcf = pcf; v.req = req; v.pcd = pcd; v.vld = vld;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stall, input logic rv,
                         input logic [31:0] tgt, input logic rdy);
        reset = rst; stall_D = stall; redirect_valid = rv; redirect_target = tgt; im_ready = rdy;
    endtask

    // Drive one cycle's inputs, then land on the next falling edge.
    task automatic step(input logic rst, input logic stall, input logic rv,
                        input logic [31:0] tgt, input logic rdy);
        drive(rst, stall, rv, tgt, rdy);
        @(negedge clk);
    endtask

    task automatic check_d(input string name, input logic [31:0] pcd, input logic vld);
        check32({name, ".valid_D"}, {31'h0, valid_D}, {31'h0, vld});
        check32({name, ".instr_D"}, instr_D, vld ? mem_word(pcd) : 32'h0);
        if (vld) check32({name, ".PC_D"}, PC_D, pcd);
    endtask

    initial begin
        // Zero-wait stream with a branch whose delay slot completes the same cycle.
        vecs[0]  = mk(0, 0, 0, 32'h0,    1, 32'h3004, 1, 32'h3000, 1);
        vecs[1]  = mk(0, 0, 0, 32'h0,    1, 32'h3008, 1, 32'h3004, 1);
        vecs[2]  = mk(0, 0, 1, 32'h3040, 1, 32'h3040, 1, 32'h3008, 1);
        vecs[3]  = mk(0, 0, 0, 32'h0,    1, 32'h3044, 1, 32'h3040, 1);
        vecs[4]  = mk(1, 0, 0, 32'h0,    1, 32'h3000, 1, 32'h0,    0);
        // Same branch, delay slot waits three cycles.
        vecs[5]  = mk(0, 0, 0, 32'h0,    1, 32'h3004, 1, 32'h3000, 1);
        vecs[6]  = mk(0, 0, 0, 32'h0,    1, 32'h3008, 1, 32'h3004, 1);
        vecs[7]  = mk(0, 0, 1, 32'h3040, 0, 32'h3008, 1, 32'h3004, 0);
        vecs[8]  = mk(0, 0, 0, 32'h0,    0, 32'h3008, 1, 32'h3004, 0);
        vecs[9]  = mk(0, 0, 0, 32'h0,    0, 32'h3008, 1, 32'h3004, 0);
        vecs[10] = mk(0, 0, 0, 32'h0,    1, 32'h3040, 1, 32'h3008, 1);
        vecs[11] = mk(0, 0, 0, 32'h0,    1, 32'h3044, 1, 32'h3040, 1);

        drive(1, 0, 0, 32'h0, 0);
        repeat (2) @(negedge clk);
        check32("reset.PC_F", PC_F, 32'h3000);
        check32("reset.im_req", {31'h0, im_req}, 32'h1);
        check32("reset.PC_D", PC_D, 32'h0);
        check32("reset.instr_D", instr_D, 32'h0);
        check32("reset.valid_D", {31'h0, valid_D}, 32'h0);

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rst, vecs[i].stall, vecs[i].rv, vecs[i].tgt, vecs[i].rdy);
            check32($sformatf("vec%0d.PC_F", i), PC_F, vecs[i].pcf);
            check32($sformatf("vec%0d.im_addr", i), im_addr, vecs[i].pcf);
            check32($sformatf("vec%0d.im_req", i), {31'h0, im_req}, {31'h0, vecs[i].req});
            check_d($sformatf("vec%0d", i), vecs[i].pcd, vecs[i].vld);
        end
        check32("no_req_300c", hits_300c, 0);

        // Stall while the 3010 fetch completes: park, hold two cycles, release.
        step(1, 0, 0, 32'h0, 1);
        repeat (4) step(0, 0, 0, 32'h0, 1);
        check32("pre_stall.PC_F", PC_F, 32'h3010);
        step(0, 1, 0, 32'h0, 1);
        check32("hold1.im_req", {31'h0, im_req}, 32'h0);
        check32("hold1.PC_F", PC_F, 32'h3014);
        check_d("hold1", 32'h300C, 1'b1);
        step(0, 1, 0, 32'h0, 1);
        check32("hold2.im_req", {31'h0, im_req}, 32'h0);
        check_d("hold2", 32'h300C, 1'b1);
        step(0, 0, 0, 32'h0, 1);
        check_d("release", 32'h3010, 1'b1);
        check32("release.im_req", {31'h0, im_req}, 32'h1);
        check32("release.im_addr", im_addr, 32'h3014);
        step(0, 0, 0, 32'h0, 1);
        check_d("after_release", 32'h3014, 1'b1);
        check32("after_release.PC_F", PC_F, 32'h3018);

        // Reset while a redirect is pending behind the 3020 fetch.
        repeat (2) step(0, 0, 0, 32'h0, 1);
        check32("pre_wait.PC_F", PC_F, 32'h3020);
        step(0, 0, 1, 32'h3200, 0);
        check32("wait.PC_F", PC_F, 32'h3020);
        step(1, 0, 0, 32'h0, 1);
        check32("mid_reset.PC_F", PC_F, 32'h3000);
        check_d("mid_reset", 32'h0, 1'b0);
        step(0, 0, 0, 32'h0, 1);
        check32("post_reset.PC_F", PC_F, 32'h3004);
        check_d("post_reset", 32'h3000, 1'b1);

`ifdef FETCH_ADEL_EN
        // jr to a misaligned target: no request, zero word with AdEL in D.
        step(0, 0, 0, 32'h0, 1);
        check32("adel_pre.exc", {27'h0, exc_code_D}, 32'h0);
        step(0, 0, 1, 32'h3002, 1);
        check32("adel.PC_F", PC_F, 32'h3002);
        check32("adel.im_req", {31'h0, im_req}, 32'h0);
        step(0, 0, 0, 32'h0, 0);
        check32("adel.PC_D", PC_D, 32'h3002);
        check32("adel.instr_D", instr_D, 32'h0);
        check32("adel.valid_D", {31'h0, valid_D}, 32'h1);
        check32("adel.exc", {27'h0, exc_code_D}, 32'h4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register, issues requests to a variable-latency instruction memory, and drives the IF/ID pipeline register. It consumes the next-PC redirect that the decode stage produces for branches and jumps. It honours the one-instruction delay slot, latching a redirect that arrives before the delay-slot fetch completes. It holds a fetched instruction when decode stalls.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_3000`: PC after reset.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `stall_D`  in  1  hazard unit: decode holds its current instruction.
- `redirect_valid`  in  1  branch taken or jump/jr in D. Only asserted with `valid_D && !stall_D`.
- `redirect_target`  in  32  next-PC target for the redirect.
- `im_req`  out  1  fetch request.
- `im_addr`  out  32  fetch address; equals `PC_F`.
- `im_ready`  in  1  `im_rdata` valid this cycle for the current request. May be high in the same cycle as `im_req`.
- `im_rdata`  in  32  instruction word.
- `PC_F`  out  32  current fetch PC.
- `PC_D`  out  32  PC of the instruction in D.
- `instr_D`  out  32  instruction in D.
- `valid_D`  out  1  D holds a real instruction; 0 means bubble.
- `exc_code_D`  out  5  only present with `FETCH_ADEL_EN`.

## Operation
States:
- FETCH: request outstanding.
- HOLD: fetched word parked because D stalled.

Registers:
- `PC_F`, `pend_valid`, `pend_target`
- hold buffer: `hold_pc`, `hold_instr`
- IF/ID: `PC_D`, `instr_D`, `valid_D`

FETCH state:
- `im_req=1`.
- On `im_ready`, `PC_F` advances to `nxt`:
  - `pend_valid ? pend_target`
  - else `redirect_valid ? redirect_target`
  - else `PC_F+4` (32-bit wrap, no overflow flag).
  - `pend_valid` clears.
- With `im_ready && !stall_D`: IF/ID loads `{PC_F, im_rdata, 1}`.
- With `im_ready && stall_D`: the word goes to the hold buffer and the state becomes HOLD. IF/ID is unchanged.
- With `!im_ready && !stall_D`: IF/ID loads a bubble (`valid_D=0`, `instr_D=0`).
- With `!im_ready && redirect_valid`: `pend_valid<=1`, `pend_target<=redirect_target`. The outstanding fetch is the delay slot.

HOLD state:
- `im_req=0`.
- While `stall_D`: everything holds.
- On `!stall_D`: IF/ID loads from the hold buffer and the state returns to FETCH.
- `redirect_valid` in HOLD (delay slot already fetched): `PC_F<=redirect_target`.

Priority rules:
- Pending redirect beats a new redirect. Both in the same cycle cannot occur legally; the pending one wins.
- Stall keeps IF/ID regardless of `im_ready`.

Reset values:
- `PC_F=RESET_PC`, state FETCH, `pend_valid=0`, `pend_target=0`.
- `PC_D=0`, `instr_D=0`, `valid_D=0`, hold buffer 0.
- `im_req=1` immediately after reset.
- Reset mid-request abandons it. An `im_ready` in the reset cycle is ignored.

## Timing
- Zero-wait memory (`im_ready` tied high): one instruction per cycle. `instr_D` shows the word fetched at `PC_F` one cycle after the request.
- N wait cycles give N bubbles in D.
- A redirect in cycle t:
  - with the delay slot completing in t: the target is requested in t+1.
  - with the delay slot pending: the target is requested the cycle after the delay slot's `im_ready`.
- HOLD → FETCH: the new request issues in the cycle after stall release. This gives one bubble-free handoff, because the held word fills D that same cycle.

## Configuration
`FETCH_ADEL_EN` defined:
- AdEL check in FETCH: if `PC_F[1:0]!=0` or `PC_F` is outside `[IM_BASE, IM_LIMIT]`, then `im_req=0`.
- That cycle is treated as `im_ready` with data `32'h0`, and `exc_code_D` is set to `EXC_ADEL` (4). Otherwise `exc_code_D=0`; the hold buffer carries the code too.
- `exc_code_D` resets to 0.

Undefined: no address check, no `exc_code_D` port.

## Structure
- Package `fetch_pkg`: `RESET_PC`, `IM_BASE=32'h3000`, `IM_LIMIT=32'h6FFF`, `EXC_ADEL=5'd4`, state enum {FETCH, HOLD}.
- One sub-module, `fetch_hold_buf`: the single-entry hold buffer, with load/clear/valid.

## Test plan
- Reset, `im_ready=1`, no stall → `PC_F` 3000, 3004, 3008…; `instr_D`/`PC_D` trail by one cycle; `valid_D=1` from cycle 2.
- Branch at 3004 redirects to 3040 while its delay slot at 3008 is completed the same cycle → D sequence 3004, 3008, 3040.
- Same redirect with the 3008 fetch taking 3 wait cycles → `pend_valid` set; D gets 3004, bubbles, 3008, 3040; 300C is never requested.
- `stall_D` for 2 cycles while `im_ready` on 3010 → state HOLD, `im_req=0`, `instr_D` unchanged. After release, D shows 3010 and the next request is 3014.
- Reset asserted mid-wait at PC 3020 → next cycle `PC_F=3000`, `valid_D=0`, `pend_valid=0`.
- With `FETCH_ADEL_EN`, `jr` to 3002 → no `im_req` at 3002; D gets `instr_D=0`, `exc_code_D=4`, `PC_D=3002`.
